// File: rtl/dmem_indirect_unit.sv
// ---------------------------------------------------------------------------
// dmem_indirect_unit
//
// Purpose:
//   Sits between the pipeline MEM-stage data port and the D-cache. Direct
//   loads/stores are forwarded combinationally with no added latency.
//   Indirect operations (LDI/STI) are expanded into two D-cache accesses:
//   a pointer read at P_mem_address, then the real read/write at the
//   (word-aligned) pointer. The pipeline sees one P_mem_resp at the end.
//
// Handshake (both sides): a request (read or write) is level-held until the
//   matching resp; resp is a single-cycle pulse; on the cycle after resp the
//   requester may drop the request or present a new one.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   indirect            current MEM-stage access is indirect
//   P_mem_*             pipeline side request / response
//   dc_*                D-cache side request / response
//   ind_count           number of completed indirect operations (wraps)
//   dbg_state           current FSM state (IDLE=0 PTR=1 GAP=2 FINAL=3 DRAIN=4)
// ---------------------------------------------------------------------------
module dmem_indirect_unit #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 indirect,
  input  logic [WIDTH-1:0]     P_mem_address,
  input  logic                 P_mem_read,
  input  logic                 P_mem_write,
  input  logic [1:0]           P_mem_byte_enable,
  input  logic [WIDTH-1:0]     P_mem_wdata,
  output logic                 P_mem_resp,
  output logic [WIDTH-1:0]     P_mem_rdata,
  output logic [WIDTH-1:0]     dc_address,
  output logic                 dc_read,
  output logic                 dc_write,
  output logic [1:0]           dc_byte_enable,
  output logic [WIDTH-1:0]     dc_wdata,
  input  logic                 dc_resp,
  input  logic [WIDTH-1:0]     dc_rdata,
  output logic [CNT_WIDTH-1:0] ind_count,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_IND_PTR   = 3'd1,
    S_IND_GAP   = 3'd2,
    S_IND_FINAL = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic [WIDTH-1:0]     r_rdata;

  // Outstanding cache request, captured when entering IND_PTR / IND_FINAL.
  // Driving the cache from these registers keeps the request stable even in
  // the cycle the pipeline withdraws, so a flush turns into a clean drain.
  logic [WIDTH-1:0]     r_req_addr;
  logic                 r_req_read;
  logic                 r_req_write;
  logic [1:0]           r_req_be;
  logic [WIDTH-1:0]     r_req_wdata;

  logic                 w_flush;
  logic                 w_wr_only;
  logic [WIDTH-1:0]     w_dc_addr;
  logic                 w_dc_read;
  logic                 w_dc_write;
  logic [1:0]           w_dc_be;
  logic [WIDTH-1:0]     w_dc_wdata;
  logic                 w_resp;
  logic [WIDTH-1:0]     w_rdata;
  logic                 w_cap_ptr;
  logic                 w_cap_final;
  logic                 w_ptr_load;
  logic                 w_count_inc;

  // Simultaneous read and write is illegal; read wins wherever it matters.
  assign w_flush   = ~P_mem_read & ~P_mem_write;
  assign w_wr_only = P_mem_write & ~P_mem_read;

  always_comb begin
    w_next      = r_state;
    w_dc_addr   = r_req_addr;
    w_dc_read   = r_req_read;
    w_dc_write  = r_req_write;
    w_dc_be     = r_req_be;
    w_dc_wdata  = r_req_wdata;
    w_resp      = 1'b0;
    w_rdata     = r_rdata;
    w_cap_ptr   = 1'b0;
    w_cap_final = 1'b0;
    w_ptr_load  = 1'b0;
    w_count_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dc_addr  = P_mem_address;
        w_dc_wdata = P_mem_wdata;
        if (indirect && !w_flush) begin
          // Pointer read starts in this very cycle.
          w_dc_read  = 1'b1;
          w_dc_write = 1'b0;
          w_dc_be    = 2'b11;
          w_cap_ptr  = 1'b1;
          // A cache answering in the request cycle skips IND_PTR.
          if (dc_resp) begin
            w_ptr_load = 1'b1;
            w_next     = S_IND_GAP;
          end else begin
            w_next     = S_IND_PTR;
          end
        end else begin
          w_dc_read  = P_mem_read;
          w_dc_write = w_wr_only;
          w_dc_be    = P_mem_byte_enable;
          w_resp     = dc_resp;
          w_rdata    = dc_rdata;
        end
      end
      S_IND_PTR: begin
        if (dc_resp) begin
          w_ptr_load = 1'b1;
          w_next     = w_flush ? S_IDLE : S_IND_GAP;
        end else if (w_flush) begin
          w_next     = S_DRAIN;
        end
      end
      S_IND_GAP: begin
        // Idle cycle so the cache sees the final access as a new request.
        w_dc_read  = 1'b0;
        w_dc_write = 1'b0;
        if (w_flush) begin
          w_next      = S_IDLE;
        end else begin
          w_cap_final = 1'b1;
          w_next      = S_IND_FINAL;
        end
      end
      S_IND_FINAL: begin
        if (dc_resp) begin
          if (!w_flush) begin
            w_resp      = 1'b1;
            w_rdata     = dc_rdata;
            w_count_inc = 1'b1;
          end
          w_next = S_IDLE;
        end else if (w_flush) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dc_resp) w_next = S_IDLE;
      end
      default: begin
        w_dc_read  = 1'b0;
        w_dc_write = 1'b0;
        w_next     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_req_addr  <= '0;
      r_req_read  <= 1'b0;
      r_req_write <= 1'b0;
      r_req_be    <= 2'b00;
      r_req_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_rdata <= w_rdata;
      if (w_ptr_load) r_ptr <= {dc_rdata[WIDTH-1:1], 1'b0};
      if (w_cap_ptr) begin
        r_req_addr  <= P_mem_address;
        r_req_read  <= 1'b1;
        r_req_write <= 1'b0;
        r_req_be    <= 2'b11;
        r_req_wdata <= P_mem_wdata;
      end else if (w_cap_final) begin
        r_req_addr  <= r_ptr;
        r_req_read  <= P_mem_read;
        r_req_write <= w_wr_only;
        r_req_be    <= P_mem_byte_enable;
        r_req_wdata <= P_mem_wdata;
      end
      if (w_count_inc) r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(P_mem_read && P_mem_write));
  end

  // Reset gates the request/response strobes, including the direct path.
  assign dc_address     = w_dc_addr;
  assign dc_read        = w_dc_read & ~reset;
  assign dc_write       = w_dc_write & ~reset;
  assign dc_byte_enable = w_dc_be;
  assign dc_wdata       = w_dc_wdata;
  assign P_mem_resp     = w_resp & ~reset;
  assign P_mem_rdata    = w_rdata;
  assign ind_count      = r_count;
  assign dbg_state      = r_state;

endmodule
